// File: rtl/mmio_arb_pkg.sv
// mmio_arb_pkg
// Shared types and constants for the two-master MMIO arbiter.
//   state_t      : arbiter FSM states (IDLE -> ISSUE -> ACK -> IDLE)
//   master_id_t  : 1-bit master index (0 = sys_bridge, 1 = second master)
//   lock_owner_t : lock owner id plus valid flag
package mmio_arb_pkg;

    localparam int MMIO_ADDR_W = 21;
    localparam int MMIO_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    typedef logic master_id_t;

    localparam master_id_t MASTER_0 = 1'b0;
    localparam master_id_t MASTER_1 = 1'b1;

    typedef struct packed {
        logic       valid;
        master_id_t id;
    } lock_owner_t;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2
// Combinational two-way round-robin pick with lock override.
// Ports:
//   req0, req1  : requests from master 0 / master 1
//   last_gnt    : master granted most recently
//   lock_valid  : a lock owner exists
//   lock_owner  : id of the lock owner (meaningful when lock_valid)
//   gnt_valid   : a winner was picked this cycle
//   gnt_id      : id of the winner (meaningful when gnt_valid)
module arb_rr2
    import mmio_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  master_id_t last_gnt,
    input  logic       lock_valid,
    input  master_id_t lock_owner,
    output logic       gnt_valid,
    output master_id_t gnt_id
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = MASTER_0;
        if (lock_valid) begin
            // While locked only the owner is eligible; the other master waits.
            gnt_id    = lock_owner;
            gnt_valid = (lock_owner == MASTER_1) ? req1 : req0;
        end else if (req0 && req1) begin
            // Tie: the master not granted last time wins.
            gnt_valid = 1'b1;
            gnt_id    = ~last_gnt;
        end else if (req0) begin
            gnt_valid = 1'b1;
            gnt_id    = MASTER_0;
        end else if (req1) begin
            gnt_valid = 1'b1;
            gnt_id    = MASTER_1;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter
// Shares the single mmio_top slave port between two bus masters using
// round-robin arbitration with an optional lock for atomic sequences.
// Every downstream strobe, address and write-data output is registered.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   mN_req/wr/lock/addr/wr_data   : master N request and attributes
//   mN_ack                        : one-cycle completion pulse to master N
//   mN_rd_data                    : master N read result, held until its next ack
//   mmio_cs/wr/rd/addr/wr_data    : registered downstream access
//   mmio_rd_data                  : combinational slave read data
//
// Handshake: a master raises req with wr/lock/addr/wr_data stable and keeps
// it high until it samples ack = 1; it drops req on that same edge. Any req
// seen high while the arbiter is in IDLE is a new transaction. A transaction
// is IDLE (grant) -> ISSUE (one strobe cycle) -> ACK (ack pulse) -> IDLE.
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int ADDR_W = MMIO_ADDR_W,
    parameter int DATA_W = MMIO_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_wr,
    input  logic              m1_wr,
    input  logic              m0_lock,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data
);

    state_t      state;
    state_t      state_next;
    master_id_t  last_gnt;
    master_id_t  gnt_id_q;
    logic        lock_bit_q;
    lock_owner_t lock_q;

    logic        gnt_valid;
    master_id_t  gnt_id;

    logic              sel_wr;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wr_data;

    arb_rr2 u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_gnt   (last_gnt),
        .lock_valid (lock_q.valid),
        .lock_owner (lock_q.id),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Winner's attributes, captured into the downstream registers on grant.
    always_comb begin
        sel_wr      = m0_wr;
        sel_lock    = m0_lock;
        sel_addr    = m0_addr;
        sel_wr_data = m0_wr_data;
        if (gnt_id == MASTER_1) begin
            sel_wr      = m1_wr;
            sel_lock    = m1_lock;
            sel_addr    = m1_addr;
            sel_wr_data = m1_wr_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_valid) state_next = ISSUE;
            ISSUE:   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs. Strobes and acks default low each
    // cycle and are set only for the single cycle that follows the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_rd      <= 1'b0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rd_data   <= '0;
            m1_rd_data   <= '0;
            last_gnt     <= MASTER_1;
            gnt_id_q     <= MASTER_0;
            lock_bit_q   <= 1'b0;
            lock_q       <= '0;
        end else begin
            mmio_cs <= 1'b0;
            mmio_wr <= 1'b0;
            mmio_rd <= 1'b0;
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        gnt_id_q     <= gnt_id;
                        last_gnt     <= gnt_id;
                        lock_bit_q   <= sel_lock;
                        mmio_cs      <= 1'b1;
                        mmio_wr      <= sel_wr;
                        mmio_rd      <= ~sel_wr;
                        mmio_addr    <= sel_addr;
                        mmio_wr_data <= sel_wr_data;
                    end
                end
                ISSUE: begin
                    // Slave data is valid while mmio_rd is asserted.
                    if (mmio_rd) begin
                        if (gnt_id_q == MASTER_1) begin
                            m1_rd_data <= mmio_rd_data;
                        end else begin
                            m0_rd_data <= mmio_rd_data;
                        end
                    end
                    m0_ack <= (gnt_id_q == MASTER_0);
                    m1_ack <= (gnt_id_q == MASTER_1);
                end
                ACK: begin
                    if (lock_bit_q) begin
                        lock_q.valid <= 1'b1;
                        lock_q.id    <= gnt_id_q;
                    end else begin
                        lock_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter
// Directed bench for mmio_arbiter: reset values, single write, single read,
// reset during ISSUE, tie alternation, lock hold/release and back-to-back
// single-master traffic.
module tb_mmio_arbiter;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m1_req;
    logic        m0_wr, m1_wr;
    logic        m0_lock, m1_lock;
    logic [20:0] m0_addr, m1_addr;
    logic [31:0] m0_wr_data, m1_wr_data;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rd_data, m1_rd_data;
    logic        mmio_cs, mmio_wr, mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data;
    logic [31:0] slave_data;

    int n_cmp;
    int n_err;
    logic [0:0] exp_q[$];

    mmio_arbiter #(.ADDR_W(21), .DATA_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0_req       (m0_req),
        .m1_req       (m1_req),
        .m0_wr        (m0_wr),
        .m1_wr        (m1_wr),
        .m0_lock      (m0_lock),
        .m1_lock      (m1_lock),
        .m0_addr      (m0_addr),
        .m1_addr      (m1_addr),
        .m0_wr_data   (m0_wr_data),
        .m1_wr_data   (m1_wr_data),
        .m0_ack       (m0_ack),
        .m1_ack       (m1_ack),
        .m0_rd_data   (m0_rd_data),
        .m1_rd_data   (m1_rd_data),
        .mmio_cs      (mmio_cs),
        .mmio_wr      (mmio_wr),
        .mmio_rd      (mmio_rd),
        .mmio_addr    (mmio_addr),
        .mmio_wr_data (mmio_wr_data),
        .mmio_rd_data (mmio_rd_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: drives data only while a read strobe is active.
    assign mmio_rd_data = (mmio_cs && mmio_rd) ? slave_data : 32'h0;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_strobes_idle(input string tag);
        chk1({tag, "_cs"}, mmio_cs, 1'b0);
        chk1({tag, "_wr"}, mmio_wr, 1'b0);
        chk1({tag, "_rd"}, mmio_rd, 1'b0);
    endtask

    initial begin
        logic [0:0] exp_id;
        n_cmp      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        m0_req     = 1'b0; m1_req     = 1'b0;
        m0_wr      = 1'b0; m1_wr      = 1'b0;
        m0_lock    = 1'b0; m1_lock    = 1'b0;
        m0_addr    = '0;   m1_addr    = '0;
        m0_wr_data = '0;   m1_wr_data = '0;
        slave_data = 32'h0;

        // ---- reset values
        #1;
        chk_strobes_idle("rst");
        chk1("rst_m0_ack", m0_ack, 1'b0);
        chk1("rst_m1_ack", m1_ack, 1'b0);
        chk32("rst_addr", 32'(mmio_addr), 32'h0);
        chk32("rst_wdata", mmio_wr_data, 32'h0);
        chk32("rst_m0_rd", m0_rd_data, 32'h0);
        chk32("rst_m1_rd", m1_rd_data, 32'h0);
        #13 reset_n = 1'b1;
        step();

        // ---- master 0 write
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h00010; m0_wr_data = 32'h0000_00FF;
        step();
        chk1("w0_cs", mmio_cs, 1'b1);
        chk1("w0_wr", mmio_wr, 1'b1);
        chk1("w0_rd", mmio_rd, 1'b0);
        chk32("w0_addr", 32'(mmio_addr), 32'h10);
        chk32("w0_wdata", mmio_wr_data, 32'hFF);
        chk1("w0_ack_early", m0_ack, 1'b0);
        step();
        chk1("w0_ack", m0_ack, 1'b1);
        chk1("w0_m1_ack", m1_ack, 1'b0);
        chk_strobes_idle("w0_ackcyc");
        step();
        m0_req = 1'b0;
        chk1("w0_ack_pulse", m0_ack, 1'b0);
        chk32("w0_addr_hold", 32'(mmio_addr), 32'h10);
        chk32("w0_m0_rd", m0_rd_data, 32'h0);

        // ---- master 1 read
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00020; slave_data = 32'hDEAD_BEEF;
        step();
        chk1("r1_cs", mmio_cs, 1'b1);
        chk1("r1_rd", mmio_rd, 1'b1);
        chk1("r1_wr", mmio_wr, 1'b0);
        chk32("r1_addr", 32'(mmio_addr), 32'h20);
        step();
        chk1("r1_ack", m1_ack, 1'b1);
        chk1("r1_m0_ack", m0_ack, 1'b0);
        chk32("r1_data", m1_rd_data, 32'hDEAD_BEEF);
        chk32("r1_m0_rd", m0_rd_data, 32'h0);
        step();
        m1_req = 1'b0;
        slave_data = 32'h0;
        chk32("r1_data_hold", m1_rd_data, 32'hDEAD_BEEF);

        // ---- reset during ISSUE
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 21'h00030; m1_wr_data = 32'h3333_3333;
        step();
        chk1("rstmid_cs_before", mmio_cs, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk_strobes_idle("rstmid");
        chk32("rstmid_addr", 32'(mmio_addr), 32'h0);
        chk32("rstmid_m1_rd", m1_rd_data, 32'h0);
        m1_req = 1'b0;
        #1 reset_n = 1'b1;
        step();
        chk1("rstmid_no_ack_a", m1_ack, 1'b0);
        step();
        chk1("rstmid_no_ack_b", m1_ack, 1'b0);
        chk1("rstmid_no_cs", mmio_cs, 1'b0);

        // ---- tie alternation from reset: 0, 1, 0, 1
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        m0_req = 1'b1; m0_wr = 1'b1; m0_lock = 1'b0; m0_addr = 21'h00100; m0_wr_data = 32'hA0A0_0000;
        m1_req = 1'b1; m1_wr = 1'b1; m1_lock = 1'b0; m1_addr = 21'h00200; m1_wr_data = 32'hB1B1_0000;
        for (int k = 0; k < 4; k++) begin
            exp_id = exp_q.pop_front();
            step();
            chk1("tie_cs", mmio_cs, 1'b1);
            chk32("tie_addr", 32'(mmio_addr), (exp_id == 1'b1) ? 32'h200 : 32'h100);
            step();
            chk1("tie_m0_ack", m0_ack, (exp_id == 1'b0));
            chk1("tie_m1_ack", m1_ack, (exp_id == 1'b1));
            step();
            chk1("tie_idle_cs", mmio_cs, 1'b0);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();

        // ---- lock: m0 locked read, pause, unlocked write; m1 waits throughout
        m0_req = 1'b1; m0_wr = 1'b0; m0_lock = 1'b1; m0_addr = 21'h00040;
        m1_req = 1'b1; m1_wr = 1'b1; m1_lock = 1'b0; m1_addr = 21'h00050; m1_wr_data = 32'h5050_5050;
        slave_data = 32'h1234_5678;
        step();
        chk32("lk_rd_addr", 32'(mmio_addr), 32'h40);
        chk1("lk_rd_rd", mmio_rd, 1'b1);
        step();
        chk1("lk_rd_ack", m0_ack, 1'b1);
        chk32("lk_rd_data", m0_rd_data, 32'h1234_5678);
        step();
        m0_req = 1'b0;
        slave_data = 32'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("lk_hold_cs", mmio_cs, 1'b0);
            chk1("lk_hold_m1_ack", m1_ack, 1'b0);
        end
        m0_req = 1'b1; m0_wr = 1'b1; m0_lock = 1'b0; m0_addr = 21'h00044; m0_wr_data = 32'h0000_A5A5;
        step();
        chk32("lk_wr_addr", 32'(mmio_addr), 32'h44);
        chk1("lk_wr_wr", mmio_wr, 1'b1);
        step();
        chk1("lk_wr_ack", m0_ack, 1'b1);
        chk1("lk_wr_m1_ack", m1_ack, 1'b0);
        chk32("lk_wr_m0_rd", m0_rd_data, 32'h1234_5678);
        step();
        m0_req = 1'b0;
        step();
        chk32("lk_m1_addr", 32'(mmio_addr), 32'h50);
        chk32("lk_m1_wdata", mmio_wr_data, 32'h5050_5050);
        step();
        chk1("lk_m1_ack", m1_ack, 1'b1);
        chk32("lk_m1_rd", m1_rd_data, 32'h0);
        step();
        m1_req = 1'b0;
        step();

        // ---- single master back-to-back: cs at t+1, t+4, t+7
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 21'h00060; m1_wr_data = 32'h6;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk1("b2b_cs", mmio_cs, (k % 3 == 1));
            chk1("b2b_ack", m1_ack, (k % 3 == 2));
            chk32("b2b_addr", 32'(mmio_addr), 32'h60 + 32'((k - 1) / 3));
            if (k == 3) begin m1_addr = 21'h00061; m1_wr_data = 32'h7; end
            if (k == 6) begin m1_addr = 21'h00062; m1_wr_data = 32'h8; end
            if (k == 9) m1_req = 1'b0;
        end
        step();
        chk1("b2b_end_cs", mmio_cs, 1'b0);
        chk32("b2b_end_addr", 32'(mmio_addr), 32'h62);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter for the 21-bit MMIO system bus. Shares the single `mmio_top` slave port between the CPU-side `sys_bridge` (master 0) and a second bus master such as a DMA or debug engine (master 1). Uses round-robin grant with an optional lock for atomic read-modify-write sequences. Sits between the bridge outputs and the `mmio_top` inputs in `soc_top`, and registers every downstream strobe.

## Interface
Parameters:
- `ADDR_W`, default 21: MMIO address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  request; held high until the matching ack.
- `m0_wr`, `m1_wr`  in  1  1 = write, 0 = read; held stable with req.
- `m0_lock`, `m1_lock`  in  1  keep the grant after this transaction.
- `m0_addr`, `m1_addr`  in  ADDR_W  word address.
- `m0_wr_data`, `m1_wr_data`  in  DATA_W  write data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rd_data`, `m1_rd_data`  out  DATA_W  read result; valid in the ack cycle, held until that master's next ack.
- `mmio_cs`, `mmio_wr`, `mmio_rd`  out  1  downstream strobes.
- `mmio_addr`  out  ADDR_W  downstream address.
- `mmio_wr_data`  out  DATA_W  downstream write data.
- `mmio_rd_data`  in  DATA_W  slave read data, combinational from `mmio_cs`/`mmio_rd`/`mmio_addr`.

## Operation
- FSM states: IDLE, ISSUE, ACK.
- **IDLE**
  - Sample both requests.
  - If a lock owner exists, consider only that owner's req.
  - Otherwise:
    - Single requester wins.
    - Both requesting: grant the master not granted last (`last_gnt`).
  - On grant, register the winner's wr/addr/wr_data/lock into downstream registers, update `last_gnt`, and go to ISSUE.
  - No request: stay in IDLE.
- **ISSUE** (exactly one cycle)
  - `mmio_cs` = 1.
  - `mmio_wr` = wr, `mmio_rd` = !wr.
  - Read: capture `mmio_rd_data` at the closing edge into the granted master's rd_data register.
  - Go to ACK.
- **ACK**
  - Strobes low.
  - Granted master's ack = 1 for one cycle.
  - Lock bit = 1: lock owner := granted master. Lock bit = 0: clear lock owner.
  - Go to IDLE.
- Master contract: a registered master drops req on the edge where it samples ack = 1. Req high in IDLE is always a new transaction.
- `mmio_addr` and `mmio_wr_data` hold their last values outside ISSUE. `mmio_cs`, `mmio_wr`, `mmio_rd` are 0 outside ISSUE.
- Non-owner requests during a lock wait indefinitely. No timeout.
- A master's rd_data is not updated by writes or by the other master's reads.

## Timing
- Reset values (`reset_n` = 0, immediate):
  - State IDLE.
  - All acks, strobes, `mmio_addr`, `mmio_wr_data` and both rd_data registers = 0.
  - `last_gnt` = 1, so master 0 wins the first tie.
  - Lock owner = none.
- Latency: req high in IDLE cycle t → `mmio_cs` in t+1 → ack in t+2.
- Throughput: one transaction per 3 cycles. A back-to-back request is seen in IDLE at t+3.
- Simultaneous requests with no lock strictly alternate: 0, 1, 0, 1…
- Request arriving in ISSUE/ACK: waits for the next IDLE. No request is dropped while req stays high.
- Lock owner's req low in IDLE: the arbiter stays in IDLE and the lock persists. The only ways to release are a lock = 0 transaction or reset.
- Reset mid-ISSUE/ACK aborts the transaction. No ack is issued and the master must re-request.

## Structure
- Package `mmio_arb_pkg`:
  - `state_t` enum {IDLE, ISSUE, ACK}.
  - `MMIO_ADDR_W` = 21, `MMIO_DATA_W` = 32.
  - `master_id_t` (1 bit) plus a lock-owner valid flag.
- Sub-module `arb_rr2`: combinational two-way round-robin pick from (req0, req1, last_gnt, lock_valid, lock_owner), producing gnt_valid and gnt_id. The FSM, registers and datapath muxes live in `mmio_arbiter`.

## Test plan
- Master 0 write (addr 0x00010, data 0x0000_00FF) → `mmio_cs` = `mmio_wr` = 1 in cycle t+1 with those values; `m0_ack` in t+2; `m1_ack` stays 0.
- Master 1 read (addr 0x00020), slave returns 0xDEAD_BEEF → `mmio_rd` = 1 in t+1; `m1_ack` and `m1_rd_data` = 0xDEAD_BEEF in t+2; `m0_rd_data` unchanged.
- Both masters hold req for 4 transactions from reset → grant order 0, 1, 0, 1, each 3 cycles apart.
- Master 0 issues read then write with lock = 1 then 0 while master 1 requests continuously → master 1 is granted only after master 0's unlocked write is acked.
- `reset_n` pulsed low during ISSUE → strobes drop to 0 immediately; no ack; next request completes normally with master 0 winning a tie.
- Single master back-to-back 3 writes → `mmio_cs` pulses at t+1, t+4, t+7; `mmio_addr` holds between pulses.
